// File: rtl/bill_pay_ctrl_if.sv
// Session bus between the payment front ends and the bill payment controller.
// The master modport drives credentials and payment beats; the slave is the controller.
interface bill_pay_ctrl_if #(
    parameter int AMT_W = 16,
    parameter int N_CH  = 4
);
    logic             login_valid;
    logic             cred_ok;
    logic [N_CH-1:0]  ch_req;
    logic [AMT_W-1:0] bill_amount;
    logic             pay_valid;
    logic [AMT_W-1:0] pay_amount;
    logic             cancel;
    logic             logged_in;
    logic             locked;
    logic [N_CH-1:0]  ch_grant;
    logic             pay_ready;
    logic [AMT_W-1:0] paid_total;
    logic             done;
    logic [AMT_W-1:0] change_amount;
    logic             timeout;
    logic             supply_on;

    modport master (
        output login_valid, cred_ok, ch_req, bill_amount, pay_valid, pay_amount, cancel,
        input  logged_in, locked, ch_grant, pay_ready, paid_total, done, change_amount,
               timeout, supply_on
    );

    modport slave (
        input  login_valid, cred_ok, ch_req, bill_amount, pay_valid, pay_amount, cancel,
        output logged_in, locked, ch_grant, pay_ready, paid_total, done, change_amount,
               timeout, supply_on
    );
endinterface

// File: rtl/bill_pay_ctrl.sv
// Session controller for the bill payment machine: login with lockout, channel
// arbitration, saturating accumulation of partial payments, timeout and supply control.
module bill_pay_ctrl #(
    parameter int AMT_W          = 16,
    parameter int N_CH           = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCK_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic            clk,
    input  logic            reset,
    bill_pay_ctrl_if.slave  bus
);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_TRIES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [AMT_W-1:0]  AMT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOCKED, S_AUTH, S_COLLECT, S_SETTLE
    } state_e;

    state_e            state_q, state_d;
    logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [AMT_W-1:0]  bill_q, bill_d;
    logic [AMT_W-1:0]  paid_total_q, paid_total_d;
    logic [AMT_W-1:0]  change_q, change_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic              supply_q, supply_d;
    logic              logged_in_q, logged_in_d;
    logic              locked_q, locked_d;
    logic              pay_ready_q, pay_ready_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic              accept;
    logic [AMT_W:0]    sum_w;
    logic [AMT_W-1:0]  paid_next;
    logic              covered;
    logic              settle_to;
    logic [N_CH-1:0]   grant_pick;
    logic              pick_found;

    // Accumulator: one extra bit catches the carry so the total clamps instead of wrapping.
    always_comb begin
        accept    = bus.pay_valid & pay_ready_q;
        sum_w     = {1'b0, paid_total_q} + {1'b0, bus.pay_amount};
        paid_next = paid_total_q;
        if (accept) paid_next = sum_w[AMT_W] ? AMT_MAX : sum_w[AMT_W-1:0];
        covered   = (paid_next >= bill_q);
    end

    always_comb begin
        grant_pick = '0;
        pick_found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.ch_req[i] && !pick_found) begin
                grant_pick[i] = 1'b1;
                pick_found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fail_cnt_q   <= '0;
            lock_cnt_q   <= '0;
            timer_q      <= '0;
            bill_q       <= '0;
            paid_total_q <= '0;
            change_q     <= '0;
            grant_q      <= '0;
            supply_q     <= 1'b1;
            logged_in_q  <= 1'b0;
            locked_q     <= 1'b0;
            pay_ready_q  <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fail_cnt_q   <= fail_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            timer_q      <= timer_d;
            bill_q       <= bill_d;
            paid_total_q <= paid_total_d;
            change_q     <= change_d;
            grant_q      <= grant_d;
            supply_q     <= supply_d;
            logged_in_q  <= logged_in_d;
            locked_q     <= locked_d;
            pay_ready_q  <= pay_ready_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fail_cnt_d = fail_cnt_q;
        lock_cnt_d = lock_cnt_q;
        timer_d    = timer_q;
        settle_to  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.login_valid) begin
                    if (bus.cred_ok) begin
                        state_d    = S_AUTH;
                        fail_cnt_d = '0;
                    end else if (fail_cnt_q == FAIL_LAST) begin
                        state_d    = S_LOCKED;
                        fail_cnt_d = '0;
                        lock_cnt_d = '0;
                    end else begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if (lock_cnt_q == LOCK_LAST) state_d = S_IDLE;
                else                         lock_cnt_d = lock_cnt_q + 1'b1;
            end
            S_AUTH: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else if (|bus.ch_req) begin
                    state_d = S_COLLECT;
                    timer_d = '0;
                end
            end
            S_COLLECT: begin
                timer_d = accept ? '0 : timer_q + 1'b1;
                // A covering beat outranks cancel, and any beat outranks timer expiry.
                if (covered || bus.cancel) begin
                    state_d = S_SETTLE;
                end else if (!accept && timer_q == TMR_LAST) begin
                    state_d   = S_SETTLE;
                    settle_to = 1'b1;
                end
            end
            S_SETTLE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        logged_in_d  = (state_d == S_AUTH) || (state_d == S_COLLECT);
        locked_d     = (state_d == S_LOCKED);
        pay_ready_d  = (state_d == S_COLLECT);
        done_d       = (state_d == S_SETTLE);
        timeout_d    = settle_to;
        bill_d       = bill_q;
        paid_total_d = paid_total_q;
        change_d     = change_q;
        supply_d     = supply_q;
        grant_d      = '0;
        if (state_q == S_AUTH && state_d == S_COLLECT) begin
            bill_d       = bus.bill_amount;
            paid_total_d = '0;
            change_d     = '0;
            grant_d      = grant_pick;
        end else if (state_q == S_COLLECT) begin
            paid_total_d = paid_next;
            if (state_d == S_COLLECT) begin
                grant_d = grant_q;
            end else begin
                change_d = covered ? paid_next - bill_q : '0;
                supply_d = covered;
            end
        end
    end

    assign bus.logged_in     = logged_in_q;
    assign bus.locked        = locked_q;
    assign bus.ch_grant      = grant_q;
    assign bus.pay_ready     = pay_ready_q;
    assign bus.paid_total    = paid_total_q;
    assign bus.done          = done_q;
    assign bus.change_amount = change_q;
    assign bus.timeout       = timeout_q;
    assign bus.supply_on     = supply_q;
endmodule

// File: tb/tb_bill_pay_ctrl.sv
// Directed bench for bill_pay_ctrl: lockout, arbitration, accumulation, saturation,
// timeout, cancel interplay and asynchronous reset mid-session.
module tb_bill_pay_ctrl;
    localparam int AMT_W = 16;
    localparam int N_CH  = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    bill_pay_ctrl_if #(.AMT_W(AMT_W), .N_CH(N_CH)) bus ();

    bill_pay_ctrl #(
        .AMT_W(AMT_W), .N_CH(N_CH), .MAX_TRIES(3), .LOCK_CYCLES(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic login_good();
        bus.login_valid = 1'b1;
        bus.cred_ok     = 1'b1;
        tick();
        bus.login_valid = 1'b0;
        bus.cred_ok     = 1'b0;
    endtask

    task automatic open_session(input logic [AMT_W-1:0] bill, input logic [N_CH-1:0] req);
        bus.bill_amount = bill;
        bus.ch_req      = req;
        tick();
        bus.ch_req      = '0;
    endtask

    task automatic beat(input logic [AMT_W-1:0] amt, input logic canc);
        bus.pay_valid  = 1'b1;
        bus.pay_amount = amt;
        bus.cancel     = canc;
        tick();
        bus.pay_valid  = 1'b0;
        bus.cancel     = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.login_valid = 1'b0;
        bus.cred_ok     = 1'b0;
        bus.ch_req      = '0;
        bus.bill_amount = '0;
        bus.pay_valid   = 1'b0;
        bus.pay_amount  = '0;
        bus.cancel      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_logged_in", bus.logged_in, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_grant", bus.ch_grant, 0);
        chk("rst_ready", bus.pay_ready, 0);
        chk("rst_paid", bus.paid_total, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_supply", bus.supply_on, 1);
        reset = 1'b0;
        tick();

        // Three bad logins -> lockout for exactly 8 cycles, good strobe inside ignored.
        bus.login_valid = 1'b1;
        bus.cred_ok     = 1'b0;
        tick();
        chk("fail1_locked", bus.locked, 0);
        tick();
        chk("fail2_locked", bus.locked, 0);
        tick();
        bus.login_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("lock_hold", bus.locked, 1);
            chk("lock_no_login", bus.logged_in, 0);
            bus.login_valid = (i == 2);
            bus.cred_ok     = (i == 2);
            tick();
        end
        bus.login_valid = 1'b0;
        bus.cred_ok     = 1'b0;
        chk("unlock", bus.locked, 0);
        chk("unlock_no_login", bus.logged_in, 0);
        login_good();
        chk("login_after_lock", bus.logged_in, 1);

        // Cancel wins over ch_req in AUTH.
        bus.cancel = 1'b1;
        bus.ch_req = 4'b0100;
        tick();
        bus.cancel = 1'b0;
        bus.ch_req = '0;
        chk("auth_cancel_logout", bus.logged_in, 0);
        chk("auth_cancel_grant", bus.ch_grant, 0);

        // Main flow: lowest-index grant, 30+50+40 against 100.
        login_good();
        open_session(16'd100, 4'b1010);
        chk("grant_lowest", bus.ch_grant, 4'b0010);
        chk("grant_ready", bus.pay_ready, 1);
        bus.ch_req = 4'b0001;
        beat(16'd30, 1'b0);
        chk("paid_30", bus.paid_total, 30);
        chk("grant_frozen", bus.ch_grant, 4'b0010);
        bus.ch_req = '0;
        beat(16'd50, 1'b0);
        chk("paid_80", bus.paid_total, 80);
        chk("no_done_80", bus.done, 0);
        beat(16'd40, 1'b0);
        chk("paid_120", bus.paid_total, 120);
        chk("main_done", bus.done, 1);
        chk("main_change", bus.change_amount, 20);
        chk("main_supply", bus.supply_on, 1);
        chk("main_ready_low", bus.pay_ready, 0);
        chk("main_no_timeout", bus.timeout, 0);
        tick();
        chk("main_done_pulse", bus.done, 0);
        chk("main_logout", bus.logged_in, 0);
        chk("main_change_hold", bus.change_amount, 20);

        // Timeout: one beat of 60 then 16 idle COLLECT cycles.
        login_good();
        open_session(16'd100, 4'b0001);
        chk("to_change_clr", bus.change_amount, 0);
        beat(16'd60, 1'b0);
        repeat (15) tick();
        chk("to_still_collect", bus.pay_ready, 1);
        chk("to_supply_kept", bus.supply_on, 1);
        tick();
        chk("to_done", bus.done, 1);
        chk("to_flag", bus.timeout, 1);
        chk("to_change", bus.change_amount, 0);
        chk("to_supply_off", bus.supply_on, 0);
        chk("to_paid", bus.paid_total, 60);
        tick();
        chk("to_flag_pulse", bus.timeout, 0);

        // First beat covers 0xFFF0; second beat is offered but never accepted.
        login_good();
        open_session(16'hFFF0, 4'b0100);
        beat(16'hFFF0, 1'b0);
        chk("big_done", bus.done, 1);
        chk("big_change", bus.change_amount, 0);
        chk("big_supply", bus.supply_on, 1);
        beat(16'h0020, 1'b0);
        chk("big_paid_hold", bus.paid_total, 16'hFFF0);

        // Saturation: 0x8000 + 0x8000 clamps to 0xFFFF which covers 0xFFFF.
        login_good();
        open_session(16'hFFFF, 4'b1000);
        beat(16'h8000, 1'b0);
        chk("sat_half", bus.paid_total, 16'h8000);
        beat(16'h8000, 1'b0);
        chk("sat_paid", bus.paid_total, 16'hFFFF);
        chk("sat_done", bus.done, 1);
        chk("sat_change", bus.change_amount, 0);
        tick();

        // Zero bill settles on the first COLLECT cycle.
        login_good();
        open_session(16'd0, 4'b1000);
        chk("zero_grant", bus.ch_grant, 4'b1000);
        tick();
        chk("zero_done", bus.done, 1);
        chk("zero_supply", bus.supply_on, 1);
        tick();

        // Completing beat with cancel, then non-completing beat with cancel.
        login_good();
        open_session(16'd50, 4'b0010);
        beat(16'd50, 1'b1);
        chk("cbeat_done", bus.done, 1);
        chk("cbeat_supply", bus.supply_on, 1);
        chk("cbeat_change", bus.change_amount, 0);
        tick();
        login_good();
        open_session(16'd50, 4'b0010);
        beat(16'd10, 1'b1);
        chk("pbeat_paid", bus.paid_total, 10);
        chk("pbeat_done", bus.done, 1);
        chk("pbeat_supply", bus.supply_on, 0);
        chk("pbeat_timeout", bus.timeout, 0);
        tick();

        // Asynchronous reset mid-COLLECT with 40 paid.
        login_good();
        open_session(16'd100, 4'b0001);
        beat(16'd40, 1'b0);
        chk("pre_rst_paid", bus.paid_total, 40);
        reset = 1'b1;
        #2;
        chk("arst_paid", bus.paid_total, 0);
        chk("arst_supply", bus.supply_on, 1);
        chk("arst_logged_in", bus.logged_in, 0);
        chk("arst_ready", bus.pay_ready, 0);
        chk("arst_grant", bus.ch_grant, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_idle", bus.logged_in, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bill_pay_ctrl.md
# bill_pay_ctrl

Parametrised session controller for the anytime electricity bill payment machine. It covers login with a failed-attempt lockout, arbitration across N payment channels, and accumulation of partial payments against a latched bill. It also handles idle timeout, change computation, and supply-enable control. It sits between the credential comparator and the payment-channel front ends (card, DD/MICR, cash, digital), and drives the supply-control relay.

## Interface
- AMT_W, 16, width of all amount fields
- N_CH, 4, number of payment channels; channel 0 has highest priority
- MAX_TRIES, 3, consecutive failed logins before lockout (≥1)
- LOCK_CYCLES, 1024, lockout duration in clk cycles (≥1)
- TIMEOUT_CYCLES, 4096, COLLECT cycles without an accepted beat before forced settle (≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- login_valid  in  1  one-cycle credential-check strobe
- cred_ok  in  1  credential match, qualified by login_valid
- ch_req  in  N_CH  channel-present bits
- bill_amount  in  AMT_W  amount due, sampled on COLLECT entry
- pay_valid  in  1  payment beat valid
- pay_amount  in  AMT_W  value of beat, for the granted channel
- cancel  in  1  user abort
- logged_in  out  1  high in AUTH and COLLECT
- locked  out  1  high in LOCKED
- ch_grant  out  N_CH  one-hot granted channel, zero outside COLLECT
- pay_ready  out  1  high in COLLECT
- paid_total  out  AMT_W  accumulated payment
- done  out  1  one-cycle pulse in SETTLE
- change_amount  out  AMT_W  overpayment, valid from SETTLE until next COLLECT entry
- timeout  out  1  one-cycle pulse in SETTLE when settle was caused by timeout
- supply_on  out  1  supply enable

## Operation
- States: IDLE, LOCKED, AUTH, COLLECT, SETTLE. Registered outputs decode the state.
- Reset values: state IDLE; fail counter 0; logged_in, locked, pay_ready, done, timeout 0; ch_grant 0; paid_total 0; change_amount 0; supply_on 1.
- IDLE:
  - login_valid & cred_ok → AUTH, fail counter cleared.
  - login_valid & !cred_ok → fail counter +1. If the counter reaches MAX_TRIES → LOCKED, counter cleared.
- LOCKED: login_valid ignored. Stays exactly LOCK_CYCLES cycles, then → IDLE.
- AUTH:
  - cancel → IDLE. cancel has priority over ch_req.
  - Else, if any ch_req bit is set: grant the lowest-index set bit, latch bill_amount, clear paid_total, clear change_amount, clear the timer, → COLLECT.
- COLLECT:
  - A beat is accepted when pay_valid & pay_ready. On acceptance, paid_total ← min(paid_total + pay_amount, 2^AMT_W−1); add is AMT_W+1 wide, saturating. Timer cleared on acceptance.
  - If the next paid_total ≥ latched bill → SETTLE on the same edge.
  - A latched bill of 0 → SETTLE on the first COLLECT cycle.
  - Else cancel → SETTLE.
  - Else no beat and timer = TIMEOUT_CYCLES−1 → SETTLE with timeout flag; otherwise timer +1.
  - ch_grant and the latched bill stay frozen; ch_req changes are ignored.
- SETTLE (one cycle, then → IDLE, i.e. logout):
  - done = 1.
  - change_amount = paid_total − bill if paid_total ≥ bill, else 0.
  - supply_on ← 1 if paid_total ≥ bill, else 0.
  - paid_total holds.
- Simultaneous events in COLLECT:
  - A completing beat plus cancel is a full settle, with change.
  - A beat plus timer expiry: the beat wins, the timer is cleared, no timeout.
  - A non-completing beat plus cancel: the beat is counted, then settle.
- Reset mid-session: immediate return to reset values. The partial payment is discarded; supply_on returns to 1.

## Timing
- Login: strobe at edge t → logged_in or locked high from t+1.
- Lockout: locked is high for exactly LOCK_CYCLES cycles.
- Channel grant: ch_req seen in AUTH at edge t → ch_grant and pay_ready high from t+1.
- Completion: the completing beat accepted at edge t → pay_ready low, done and change_amount valid in cycle t+1 → logged_in low from t+2.
- Timeout: TIMEOUT_CYCLES consecutive COLLECT cycles without a beat → SETTLE in the following cycle.
- Updates: paid_total updates one edge after the accepting cycle. supply_on changes only on the SETTLE-entry edge.

## Test plan
Use AMT_W=16, N_CH=4, MAX_TRIES=3, LOCK_CYCLES=8, TIMEOUT_CYCLES=16.
- Reset asserted mid-COLLECT with paid_total=40 → all outputs return to reset values asynchronously, supply_on=1, state IDLE.
- Three login_valid with cred_ok=0 → locked=1 for exactly 8 cycles. A cred_ok=1 strobe during lock is ignored. After unlock, a good login → logged_in=1.
- Good login; ch_req=4'b1010, bill=100 → ch_grant=4'b0010. Beats 30, 50, 40 → paid_total 30/80/120, done one cycle later, change_amount=20, supply_on=1.
- bill=100, one beat of 60, then 16 idle cycles → timeout=1 and done=1 in the same cycle, change_amount=0, supply_on=0.
- bill=0xFFF0, beats 0xFFF0 and 0x0020 with the first completing → settle after the first beat. Separately, bill=0xFFFF with beats 0x8000 twice → paid_total saturates at 0xFFFF, done, change_amount=0.
- bill=50, beat of 50 with cancel in the same cycle → full settle, supply_on=1. A second run with a beat of 10 plus cancel → paid_total=10, supply_on=0, timeout=0.
